// File: rtl/fifo_sym_scheduler_pkg.sv
// Shared types and helpers for the FIFO-to-symbol read scheduler and its
// symbol-rate counter.
package fifo_sym_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAP  = 2'd2,
    ST_FULL = 2'd3
  } gather_state_e;

  localparam int UF_COUNT_W = 8;

  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

  // Gathering one bit costs two cycles, so a period shorter than that starves the mapper.
  function automatic bit sym_cfg_ok(input int bits, input int clks);
    return (bits >= 1) && (bits <= 4) && (clks >= 2 * bits);
  endfunction

endpackage

// File: rtl/fifo_sym_scheduler_rate.sv
// Free-running symbol-period counter with a one-cycle boundary strobe on the
// last enabled cycle of each period.
module sym_rate_counter
  import fifo_sym_scheduler_pkg::*;
#(
  parameter int CLKS_PER_SYM = 8
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic en_i,
  output logic boundary_o
);

  localparam int CW = cnt_width(CLKS_PER_SYM);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SYM - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    boundary_o = en_i && (cnt_q == LAST);
    cnt_d      = cnt_q;
    if (en_i) begin
      cnt_d = boundary_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_sym_scheduler.sv
// Drains a 1-bit FIFO, packs bits MSB-first into symbols and emits one symbol
// per period, substituting IDLE_SYM (with an underflow strobe) when not ready.
module fifo_sym_scheduler
  import fifo_sym_scheduler_pkg::*;
#(
  parameter int                      BITS_PER_SYM = 2,
  parameter int                      CLKS_PER_SYM = 8,
  parameter logic [BITS_PER_SYM-1:0] IDLE_SYM     = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic                    fEmpty,
  input  logic                    fDout,
  output logic                    fREn,
  output logic [BITS_PER_SYM-1:0] symOut,
  output logic                    symValid,
  output logic                    underflow,
  output logic [UF_COUNT_W-1:0]   ufCount
);

  if (!sym_cfg_ok(BITS_PER_SYM, CLKS_PER_SYM)) begin : g_cfg_err
    $error("fifo_sym_scheduler: need 1<=BITS_PER_SYM<=4 and CLKS_PER_SYM>=2*BITS_PER_SYM");
  end

  // bitCnt reaches BITS_PER_SYM after the last capture and holds until emitted.
  localparam int BCW = $clog2(BITS_PER_SYM + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS_PER_SYM - 1);

  logic boundary;

  gather_state_e             state_q, state_d;
  logic [BITS_PER_SYM-1:0]   sh_q, sh_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_SYM-1:0]   sym_q, sym_d;
  logic                      valid_q, valid_d;
  logic                      uf_q, uf_d;
  logic [UF_COUNT_W-1:0]     uf_cnt_q, uf_cnt_d;

  sym_rate_counter #(
    .CLKS_PER_SYM(CLKS_PER_SYM)
  ) u_rate (
    .clk_i     (CLK),
    .srst_i    (RST),
    .en_i      (en),
    .boundary_o(boundary)
  );

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    sym_d     = sym_q;
    valid_d   = 1'b0;
    uf_d      = 1'b0;
    uf_cnt_d  = uf_cnt_q;
    fREn      = 1'b0;

    case (state_q)
      ST_IDLE: if (en) state_d = ST_REQ;
      ST_REQ: begin
        if (en && !fEmpty) begin
          fREn    = 1'b1;
          state_d = ST_CAP;
        end
      end
      // A capture completes even with en low: the FIFO has already popped the bit.
      ST_CAP: begin
        sh_d      = BITS_PER_SYM'({sh_q, fDout});
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = (bit_cnt_q == LAST_BIT) ? ST_FULL : ST_REQ;
      end
      ST_FULL: begin
        if (boundary) begin
          sym_d     = sh_q;
          bit_cnt_d = '0;
          state_d   = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Late symbols are not dropped: gathering carries on and they go out next period.
    if (boundary) begin
      valid_d = 1'b1;
      if (state_q != ST_FULL) begin
        sym_d = IDLE_SYM;
        uf_d  = 1'b1;
        if (uf_cnt_q != '1) uf_cnt_d = uf_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      sym_q     <= IDLE_SYM;
      valid_q   <= 1'b0;
      uf_q      <= 1'b0;
      uf_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      sym_q     <= sym_d;
      valid_q   <= valid_d;
      uf_q      <= uf_d;
      uf_cnt_q  <= uf_cnt_d;
    end
  end

  assign symOut    = sym_q;
  assign symValid  = valid_q;
  assign underflow = uf_q;
  assign ufCount   = uf_cnt_q;

endmodule

// File: doc/fifo_sym_scheduler.md
# fifo_sym_scheduler

Read-side controller for the 1-bit synchronous FIFO (`synFIFO`) that feeds the modulators. It drains the FIFO bit stream and packs it MSB-first into fixed-width symbols. It presents one symbol per symbol period to the downstream mapper (BPSK/QPSK/etc.) and substitutes an idle symbol, with an underflow flag, when the FIFO cannot supply a full symbol in time.

## Interface
- `BITS_PER_SYM`, 2, bits per symbol (1..4).
- `CLKS_PER_SYM`, 8, clock cycles per symbol period; must be ≥ 2*`BITS_PER_SYM` for sustained throughput.
- `IDLE_SYM`, 0, symbol emitted on underflow and after reset.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `en`  in  1  run enable; gates the symbol-rate counter and new FIFO reads.
- `fEmpty`  in  1  FIFO `bEmpty`.
- `fDout`  in  1  FIFO `dOut`; valid the cycle after `fREn` is sampled high.
- `fREn`  out  1  FIFO `rEN`; combinational.
- `symOut`  out  `BITS_PER_SYM`  current symbol, registered, held for a full period.
- `symValid`  out  1  one-cycle strobe: `symOut` updated this cycle.
- `underflow`  out  1  one-cycle strobe, coincident with `symValid`, when `IDLE_SYM` was substituted.
- `ufCount`  out  8  underflow count, saturates at 255.

## Operation
- Symbol-rate counter `cnt`: 0..`CLKS_PER_SYM`-1. Increments when `en`=1, wraps to 0, holds when `en`=0. Boundary = `en` && `cnt`==`CLKS_PER_SYM`-1.
- Gather FSM, states IDLE, REQ, CAP, FULL:
  - IDLE → REQ when `en`.
  - REQ: `fREn` = `en` && !`fEmpty`. If asserted → CAP, else stay.
  - CAP: shift `fDout` into `shReg` (first bit read ends up as MSB) and increment `bitCnt`. If `bitCnt` was `BITS_PER_SYM`-1 → FULL, else → REQ.
  - FULL: wait. At the boundary, `symOut` ← `shReg`, clear `bitCnt`, → REQ.
- At a boundary in any state other than FULL:
  - `symOut` ← `IDLE_SYM`, pulse `underflow`, increment `ufCount` (saturating).
  - Partially gathered bits are retained; no FIFO data is ever dropped.
  - FSM state is unchanged.
- A boundary in the same cycle as the CAP of the last bit counts as an underflow. That completed symbol goes out at the next boundary.
- `en`=0 mid-gather: a pending CAP still completes; REQ issues no reads; no boundaries occur.
- `fREn` is never asserted when `fEmpty`=1, so the FIFO underflow path is never exercised.

## Timing
- Reset values: `symOut`=`IDLE_SYM`; `symValid`, `underflow`, `fREn`=0; `ufCount`=0; `cnt`=0, `bitCnt`=0, `shReg`=0; FSM=IDLE.
- `RST` overrides `en` and clears everything in the same edge, including mid-gather. Bits already read out of the FIFO are discarded.
- `en` is sampled high at edge 0. The first boundary is the edge where `cnt`=`CLKS_PER_SYM`-1 (edge `CLKS_PER_SYM`-1). `symOut` and `symValid`/`underflow` are visible after that edge.
- With `en` held high, `symValid` pulses every `CLKS_PER_SYM` cycles exactly.
- Each bit takes 2 cycles: REQ with `fREn`=1, then CAP. A full symbol from a non-empty FIFO takes 2*`BITS_PER_SYM` cycles (plus 1 from IDLE).

## Structure
- Shared package/include holds:
  - FSM state encodings: IDLE=0, REQ=1, CAP=2, FULL=3.
  - The `CLKS_PER_SYM` ≥ 2*`BITS_PER_SYM` check as an elaboration-time assertion.
  - Counter width derived from `CLKS_PER_SYM`.
- One sub-module, `sym_rate_counter`: `cnt` plus boundary strobe generation, reused by the modulator symbol clocks.
- Top level instantiates the counter, gather FSM, shift register, and output/statistics registers.

## Test plan
All scenarios use `BITS_PER_SYM`=2 and `CLKS_PER_SYM`=8, with a real `synFIFO` instance.
1. Preload FIFO 1,0,0,1,1,1, then `en`=1 → `symOut` = 2'b10, 2'b01, 2'b11 at 8-cycle intervals, `underflow`=0, `fEmpty`=1 afterwards.
2. Empty FIFO, `en`=1 for 32 cycles → four `symValid` pulses, each with `underflow`=1, `symOut`=2'b00, `ufCount`=4, `fREn` never high.
3. Write 1 bit (1), wait one boundary, then write 0 → first boundary underflow; next boundary `symOut`=2'b10, `underflow`=0; no bit lost.
4. Preload 8 bits, drop `en` for 20 cycles mid-stream → no `symValid` and `cnt` frozen while low; the symbol sequence resumes unchanged; total symbols = 4.
5. Assert `RST` during CAP of the second bit → next cycle all outputs at reset values, FSM IDLE, `ufCount`=0; the next symbol starts from fresh FIFO data.
6. Force 300 underflows → `ufCount` saturates at 255.
